// File: rtl/lut_or_checker.sv
// lut_or_checker: checks a LUT OR primitive's y against a|b through a LATENCY-aligned expected pipe.
// Define LUT_OR_CHECK_STOP_ON_FAIL_EN to end the run at the first mismatch.
module lut_or_checker #(
    parameter int NUM_SAMPLES = 16,
    parameter int LATENCY     = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] first_fail_idx
);
`ifdef LUT_OR_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] issued;
    logic clear, accept, pv, pe, cmp, mism, last, flush;
    assign clear  = start && state != RUN;
    assign accept = state == RUN && in_valid && issued < CNT_W'(NUM_SAMPLES);
    assign cmp    = state == RUN && pv;
    assign mism   = cmp && y != pe;
    assign last   = cmp && sample_count == CNT_W'(NUM_SAMPLES - 1);
    assign flush  = clear || (STOP && mism);
    generate
        if (LATENCY == 0) begin : g_comb
            assign pv = accept;
            assign pe = a | b;
        end else begin : g_pipe
            logic [LATENCY-1:0] vq, eq;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    vq <= '0;
                    eq <= '0;
                end else begin
                    vq <= flush ? '0 : LATENCY'({vq, accept});
                    eq <= LATENCY'({eq, a | b});
                end
            end
            assign pv = vq[LATENCY-1];
            assign pe = eq[LATENCY-1];
        end
    endgenerate
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (last || (STOP && mism)) ? DONE : RUN;
            DONE:    state_nx = start ? RUN : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
        pass = done && err_count == 16'd0;
    end
    // err_count of zero doubles as "no mismatch yet" for capturing the first failing index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issued         <= '0;
            sample_count   <= '0;
            err_count      <= '0;
            first_fail_idx <= '1;
        end else if (clear) begin
            issued         <= '0;
            sample_count   <= '0;
            err_count      <= '0;
            first_fail_idx <= '1;
        end else begin
            if (accept)
                issued <= issued + 1'b1;
            if (cmp)
                sample_count <= sample_count + 1'b1;
            if (mism && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            if (mism && err_count == 16'd0)
                first_fail_idx <= sample_count;
        end
    end
endmodule

// File: tb/tb_lut_or_checker.sv
// tb_lut_or_checker: directed runs on three checker configurations with a queue of expected run results.
module tb_lut_or_checker;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, a = 1'b0, b = 1'b0, kill = 1'b0;
    logic st [3];
    logic r1, r2, y0;
    logic busy [3], done [3], pass [3];
    logic [15:0] err [3];
    logic [31:0] sc [3], ffi [3];
    int total = 0, passed = 0;
    typedef struct {
        int          done_j;
        logic        pass;
        logic [15:0] err;
        logic [31:0] sc;
        logic [31:0] ffi;
    } exp_t;
    exp_t sb [$];
    always #5 clock = ~clock;
    // two-cycle registered OR feeding the LATENCY=2 checker
    always @(posedge clock) begin
        r1 <= a | b;
        r2 <= r1;
    end
    assign y0 = (a | b) & ~kill;
    lut_or_checker #(.NUM_SAMPLES(4), .LATENCY(0)) u0 (
        .clock(clock), .reset(reset), .start(st[0]), .in_valid(in_valid), .a(a), .b(b), .y(y0),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
        .sample_count(sc[0]), .first_fail_idx(ffi[0]));
    lut_or_checker #(.NUM_SAMPLES(4), .LATENCY(2)) u1 (
        .clock(clock), .reset(reset), .start(st[1]), .in_valid(in_valid), .a(a), .b(b), .y(r2),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
        .sample_count(sc[1]), .first_fail_idx(ffi[1]));
    lut_or_checker #(.NUM_SAMPLES(8), .LATENCY(0)) u2 (
        .clock(clock), .reset(reset), .start(st[2]), .in_valid(in_valid), .a(a), .b(b), .y(y0),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]),
        .sample_count(sc[2]), .first_fail_idx(ffi[2]));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic check_idle(input int k, input string tag);
        chk({tag, "_busy"}, busy[k], 0);
        chk({tag, "_done"}, done[k], 0);
        chk({tag, "_pass"}, pass[k], 0);
        chk({tag, "_err"}, err[k], 0);
        chk({tag, "_sc"}, sc[k], 0);
        chk({tag, "_ffi"}, ffi[k], 32'hFFFF_FFFF);
    endtask
    // pat 0: (a,b) from sample index bits; pat 1: (1,0). kill_mask forces y low on those sample indices.
    task automatic run(input int k, input int period, input int pat, input int kill_mask, input int mid_start);
        int j, idx;
        exp_t e;
        @(posedge clock); #1;
        st[k] = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        st[k] = 1'b0;
        idx = 0;
        j = 1;
        chk("busy_first_run_cycle", busy[k], 1);
        while (!done[k] && j < 64) begin
            st[k] = (j == mid_start);
            in_valid = ((j - 1) % period) == 0;
            a = pat != 0 ? 1'b1 : idx[1];
            b = pat != 0 ? 1'b0 : idx[0];
            kill = in_valid && idx < 32 && kill_mask[idx];
            if (in_valid) idx++;
            @(posedge clock); #1;
            j++;
        end
        in_valid = 1'b0;
        kill = 1'b0;
        st[k] = 1'b0;
        chk("done_within_budget", done[k], 1);
        chk("busy_low_at_done", busy[k], 0);
        e = sb.pop_front();
        chk("done_cycle", j, e.done_j);
        chk("pass", pass[k], e.pass);
        chk("err_count", err[k], e.err);
        chk("sample_count", sc[k], e.sc);
        chk("first_fail_idx", ffi[k], e.ffi);
        repeat (3) @(posedge clock);
        #1;
        chk("done_holds", done[k], 1);
        chk("sample_count_holds", sc[k], e.sc);
    endtask
    initial begin
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_idle(0, "reset");
        reset = 1'b1;
        sb.push_back('{5, 1'b1, 16'd0, 32'd4, 32'hFFFF_FFFF});
        run(0, 1, 0, 0, 0);
        sb.push_back('{7, 1'b1, 16'd0, 32'd4, 32'hFFFF_FFFF});
        run(1, 1, 1, 0, 0);
`ifdef LUT_OR_CHECK_STOP_ON_FAIL_EN
        sb.push_back('{4, 1'b0, 16'd1, 32'd3, 32'd2});
`else
        sb.push_back('{9, 1'b0, 16'd2, 32'd8, 32'd2});
`endif
        run(2, 1, 1, 36, 0);
        sb.push_back('{11, 1'b1, 16'd0, 32'd4, 32'hFFFF_FFFF});
        run(0, 3, 0, 0, 5);
        @(posedge clock); #1;
        st[1] = 1'b1;
        @(posedge clock); #1;
        st[1] = 1'b0;
        in_valid = 1'b1;
        a = 1'b1;
        b = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("sc_before_reset", sc[1], 1);
        #2 reset = 1'b0;
        #1 check_idle(1, "async_reset");
        @(posedge clock); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        sb.push_back('{7, 1'b1, 16'd0, 32'd4, 32'hFFFF_FFFF});
        run(1, 1, 1, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected run to finish");
        $fatal(1);
    end
endmodule
